// File: rtl/carry_or_pkg.sv
// Shared types and elaboration-time helpers for the iterative wide-OR reducer.
package carry_or_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Index width never collapses to zero, even for a one-bit word.
    function automatic int idx_w(input int width);
        return (clog2(width) < 1) ? 1 : clog2(width);
    endfunction

endpackage

// File: rtl/carry_or_seq_chunk_prio_enc.sv
// Combinational any-set detector for one chunk; with CARRY_OR_FIRST_IDX_EN it also
// priority-encodes the lowest set bit offset.
module chunk_prio_enc
    import carry_or_pkg::*;
#(
    parameter int CHUNK = 6,
    localparam int OFF_W = idx_w(CHUNK)
) (
    input  logic [CHUNK-1:0] chunk,
`ifdef CARRY_OR_FIRST_IDX_EN
    output logic [OFF_W-1:0] off,
`endif
    output logic             any
);

    assign any = |chunk;

`ifdef CARRY_OR_FIRST_IDX_EN
    // Walk from the top so the lowest set bit is the last one written.
    always_comb begin
        off = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) off = OFF_W'(i);
        end
    end
`endif

endmodule

// File: rtl/carry_or_seq.sv
// Iterative wide OR reducer: scans a captured word CHUNK bits per cycle, exits on the
// first non-zero chunk. Define CARRY_OR_FIRST_IDX_EN to add the lowest set-bit index.
module carry_or_seq
    import carry_or_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 6,
    localparam int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_any,
`ifdef CARRY_OR_FIRST_IDX_EN
    output logic [IDX_W-1:0] out_idx,
`endif
    output logic             busy
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int PAD_W      = NUM_CHUNKS * CHUNK;
    localparam int CNT_W      = clog2(NUM_CHUNKS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

    state_t           state;
    logic [PAD_W-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             hit;

`ifdef CARRY_OR_FIRST_IDX_EN
    localparam int OFF_W = idx_w(CHUNK);
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] hit_idx;

    assign hit_idx = IDX_W'(cnt * CHUNK) + IDX_W'(off);
`endif

    // The current chunk always sits in the low bits; the word shifts down each cycle.
    chunk_prio_enc #(.CHUNK(CHUNK)) u_enc (
        .chunk (sreg[CHUNK-1:0]),
`ifdef CARRY_OR_FIRST_IDX_EN
        .off   (off),
`endif
        .any   (hit)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_any   <= 1'b0;
`ifdef CARRY_OR_FIRST_IDX_EN
            out_idx   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= PAD_W'(dat);
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        out_any   <= 1'b1;
`ifdef CARRY_OR_FIRST_IDX_EN
                        out_idx   <= hit_idx;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cnt == LAST) begin
                        out_any   <= 1'b0;
`ifdef CARRY_OR_FIRST_IDX_EN
                        out_idx   <= '0;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        sreg <= sreg >> CHUNK;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_carry_or_seq.sv
// Bench for carry_or_seq: a 32/6 instance and a 7/3 instance (padding case), driven
// by directed and random words and checked against a bit-scan reference model.
module tb_carry_or_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] dat;

    logic b_in_ready, b_out_valid, b_out_any, b_busy;
    logic s_in_ready, s_out_valid, s_out_any, s_busy;
    logic o_in_ready, o_valid, o_any, o_busy;
`ifdef CARRY_OR_FIRST_IDX_EN
    logic [4:0] b_out_idx;
    logic [2:0] s_out_idx;
    logic [7:0] o_idx;
`endif

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    carry_or_seq #(.WIDTH(32), .CHUNK(6)) u_big (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (b_in_ready),
        .dat       (dat),
        .out_valid (b_out_valid),
        .out_ready (out_ready & ~sel),
        .out_any   (b_out_any),
`ifdef CARRY_OR_FIRST_IDX_EN
        .out_idx   (b_out_idx),
`endif
        .busy      (b_busy)
    );

    carry_or_seq #(.WIDTH(7), .CHUNK(3)) u_small (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (s_in_ready),
        .dat       (dat[6:0]),
        .out_valid (s_out_valid),
        .out_ready (out_ready & sel),
        .out_any   (s_out_any),
`ifdef CARRY_OR_FIRST_IDX_EN
        .out_idx   (s_out_idx),
`endif
        .busy      (s_busy)
    );

    assign o_in_ready = sel ? s_in_ready  : b_in_ready;
    assign o_valid    = sel ? s_out_valid : b_out_valid;
    assign o_any      = sel ? s_out_any   : b_out_any;
    assign o_busy     = sel ? s_busy      : b_busy;
`ifdef CARRY_OR_FIRST_IDX_EN
    assign o_idx      = sel ? 8'(s_out_idx) : 8'(b_out_idx);
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {latency edge count, any, 7'b0, lowest set index} from a plain bit scan.
    function automatic logic [23:0] model(input logic [31:0] d, input int w, input int c);
        int nch;
        int idx;
        nch = (w + c - 1) / c;
        idx = -1;
        for (int i = 0; i < w; i++) begin
            if (d[i] && idx < 0) idx = i;
        end
        if (idx < 0) return {8'(1 + nch), 1'b0, 7'd0, 8'd0};
        return {8'(2 + idx / c), 1'b1, 7'd0, 8'(idx)};
    endfunction

    // Offers one word, measures latency in edges from capture, holds the result for
    // 'hold' cycles, then completes the handshake.
    task automatic send(input logic [31:0] d, input int hold);
        int          w;
        int          c;
        int          n;
        bit          got;
        logic [23:0] e;
        logic [31:0] dm;
        w  = sel ? 7 : 32;
        c  = sel ? 3 : 6;
        dm = (w == 32) ? d : (d & ((32'd1 << w) - 32'd1));
        exp_q.push_back(model(dm, w, c));

        n = 0;
        while (!o_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before", 32'(o_in_ready), 32'd1);
        dat      = dm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dat      = $urandom;

        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (o_valid) got = 1'b1;
        end
        e = exp_q.pop_front();
        check("out_valid_seen", 32'(got), 32'd1);
        // out_valid first updates at edge T+n, so the edge that samples it is T+n+1.
        check("latency", 32'(n + 1), 32'(e[23:16]));
        check("out_any", 32'(o_any), 32'(e[15]));
`ifdef CARRY_OR_FIRST_IDX_EN
        check("out_idx", 32'(o_idx), 32'(e[7:0]));
`endif

        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_any", 32'(o_any), 32'(e[15]));
`ifdef CARRY_OR_FIRST_IDX_EN
            check("hold_idx", 32'(o_idx), 32'(e[7:0]));
`endif
            check("hold_in_ready", 32'(o_in_ready), 32'd0);
            check("hold_busy", 32'(o_busy), 32'd1);
            @(negedge clk);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("released_valid", 32'(o_valid), 32'd0);
        check("in_ready_after", 32'(o_in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int          mode;
        bit          seen;

        // Clock/reset
        sel       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dat       = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_big_valid", 32'(b_out_valid), 32'd0);
        check("rst_big_any", 32'(b_out_any), 32'd0);
        check("rst_big_busy", 32'(b_busy), 32'd0);
        check("rst_big_in_ready", 32'(b_in_ready), 32'd1);
        check("rst_small_valid", 32'(s_out_valid), 32'd0);
        check("rst_small_in_ready", 32'(s_in_ready), 32'd1);
`ifdef CARRY_OR_FIRST_IDX_EN
        check("rst_big_idx", 32'(b_out_idx), 32'd0);
        check("rst_small_idx", 32'(s_out_idx), 32'd0);
`endif

        // Directed words on the 32/6 instance
        send(32'h0000_0000, 1);
        send(32'h0000_0001, 0);
        send(32'h8000_2000, 2);
        send(32'h8000_0000, 5);

        // Reset mid-scan: the pending result must never appear
        dat      = 32'h8000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        check("rst_abort_no_valid", 32'(seen), 32'd0);
        check("rst_abort_in_ready", 32'(o_in_ready), 32'd1);
        check("rst_abort_busy", 32'(o_busy), 32'd0);
        send(32'h0000_0004, 0);

        // Random words, biased toward sparse and zero patterns
        for (int k = 0; k < 16; k++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0:       r = 32'h0;
                1:       r = 32'h1 << $urandom_range(0, 31);
                2:       r = $urandom;
                default: r = $urandom & ~((32'h1 << $urandom_range(0, 31)) - 32'h1);
            endcase
            send(r, $urandom_range(0, 3));
        end

        // 7/3 instance: padding bits beyond bit 6 must stay invisible
        sel = 1'b1;
        @(negedge clk);
        send(32'h0000_0040, 1);
        send(32'h0000_0000, 0);
        send(32'hFFFF_FF80, 0);
        for (int k = 0; k < 6; k++) begin
            send($urandom_range(0, 127), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
